mm_operand_serializer: RTL and testbench
========================================

MM_OPERAND_SERIALIZER -- requirements
Module: mm_operand_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand word width in bits; legal range is 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-006 SHALL have port in_a, input, WIDTH bits: operand A, unsigned.
REQ-007 SHALL have port in_b, input, WIDTH bits: operand B, unsigned.
REQ-008 SHALL have port a_bit, output, 1 bit: serial A stream to the downstream bit-serial multiplier, MSB first.
REQ-009 SHALL have port b_bit, output, 1 bit: serial B stream, MSB first, bit-aligned with a_bit.
REQ-010 SHALL have port bit_valid, output, 1 bit: a_bit and b_bit carry operand bits this cycle.
REQ-011 SHALL have port word_done, output, 1 bit: high during the cycle that carries bit 0 (LSB) of a word.
REQ-012 SHALL have port busy, output, 1 bit: high when the holding register or the shifter is occupied.

Function
REQ-013 SHALL accept a pair on any rising edge where in_valid and in_ready are both high, capturing in_a and in_b into a one-entry holding register.
REQ-014 SHALL drive in_ready = !hold_valid OR load_now, where load_now = hold_valid AND (state==IDLE OR last-bit cycle), so a full holding register that is draining can accept a new pair in the same cycle.
REQ-015 SHALL implement two states: IDLE (no word shifting) and SHIFT (a word is being emitted).
REQ-016 SHALL, on load_now, copy the holding register into the A and B shift registers, reset the bit counter to 0, and enter or remain in SHIFT at that edge.
REQ-017 SHALL drive a_bit and b_bit from the MSBs of the shift registers; in SHIFT each edge shifts left by one bit and fills bit 0 with 0.
REQ-018 SHALL assert bit_valid exactly when state==SHIFT, and assert word_done when state==SHIFT and counter==WIDTH-1.
REQ-019 SHALL, in the last-bit cycle, go to IDLE if no load_now occurs; otherwise it SHALL load the next word so that bit WIDTH-1 of the next word immediately follows bit 0 of the current word.
REQ-020 SHALL drive a_bit = b_bit = 0 in IDLE, so the downstream shift registers fill with zeros.
REQ-021 SHALL have a latency of 1 cycle from the accept edge to the first bit (the MSB) at the outputs when idle; a word occupies exactly WIDTH consecutive bit_valid cycles.
REQ-022 SHALL sustain throughput of one word per WIDTH cycles, with no bubble while in_valid is held high.
REQ-023 SHALL never drop, duplicate or reorder accepted words; in_a and in_b SHALL be ignored when no handshake occurs.
REQ-024 SHALL drive busy = hold_valid OR (state==SHIFT).

Reset
REQ-025 SHALL, while rst_n is low, force state=IDLE, hold_valid=0, counter=0, shift registers=0, a_bit=b_bit=bit_valid=word_done=busy=0, and in_ready=1.
REQ-026 SHALL, on reset asserted mid-word, abandon the word and the holding-register contents immediately without emitting further bits; after rst_n rises, the first accepted pair SHALL be serialized normally.

Verification
REQ-027 SHALL pass the single-word test: WIDTH=16, accept in_a=16'hA5C3 and in_b=16'h0001 from idle -> over the next 16 cycles a_bit = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 and b_bit = fifteen 0s then 1; bit_valid high for 16 cycles; word_done only on the 16th; then IDLE with zero outputs.
REQ-028 SHALL pass the back-to-back test: in_valid held high with pairs (16'hFFFF,16'h0000), (16'h8000,16'h8000), (16'h1234,16'h4321) -> 48 contiguous bit_valid cycles, word_done on cycles 16, 32 and 48, and bits matching MSB-first order with no gap.
REQ-029 SHALL pass the backpressure test: a second pair presented while the holding register is full and not draining -> in_ready low; the pair is accepted in the last-bit cycle of the current word; no loss.
REQ-030 SHALL pass the reset mid-word test: rst_n driven low at bit 7 of a word with a second word held -> all outputs 0 asynchronously; after release, a new pair 16'h0F0F is emitted intact and the held word never appears.
REQ-031 SHALL pass the end-to-end check: the serializer drives the downstream bit-serial 16x16 multiplier with random pairs -> that stage's full shift registers equal in_a/in_b in the cycle after each word_done, and its parity output matches a reference model of XOR-reduce(a*b) at its documented latency.

Source files
------------

// File: rtl/mm_operand_serializer.sv
// Operand serializer: one-entry holding register feeding MSB-first shift registers
// that stream A/B operand pairs to a downstream bit-serial multiplier.
`timescale 1ns/1ps
module mm_operand_serializer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             a_bit,
   output logic             b_bit,
   output logic             bit_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic             hold_valid;
   logic [WIDTH-1:0] hold_a;
   logic [WIDTH-1:0] hold_b;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;

   logic last_bit;
   logic load_now;
   logic accept;

   assign last_bit  = (state == SHIFT) && (cnt == LAST_IDX);
   // Reloading in the last-bit cycle frees the holding register, so a new pair
   // can land in it at the same edge and the stream stays gap-free.
   assign load_now  = hold_valid && ((state == IDLE) || last_bit);
   assign in_ready  = !hold_valid || load_now;
   assign accept    = in_valid && in_ready;

   assign a_bit     = sh_a[WIDTH-1];
   assign b_bit     = sh_b[WIDTH-1];
   assign bit_valid = (state == SHIFT);
   assign word_done = last_bit;
   assign busy      = hold_valid || (state == SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_valid <= 1'b0;
         hold_a     <= '0;
         hold_b     <= '0;
         sh_a       <= '0;
         sh_b       <= '0;
         cnt        <= '0;
      end else begin
         if (accept) begin
            hold_a     <= in_a;
            hold_b     <= in_b;
            hold_valid <= 1'b1;
         end else if (load_now) begin
            hold_valid <= 1'b0;
         end

         // Zero fill guarantees the shifters are empty by the time IDLE is entered.
         if (load_now) begin
            sh_a  <= hold_a;
            sh_b  <= hold_b;
            cnt   <= '0;
            state <= SHIFT;
         end else if (state == SHIFT) begin
            sh_a <= {sh_a[WIDTH-2:0], 1'b0};
            sh_b <= {sh_b[WIDTH-2:0], 1'b0};
            if (last_bit) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mm_operand_serializer.sv
// Self-checking bench for mm_operand_serializer: a bit-stream/word scoreboard plus a
// downstream deserializer and parity reference model check every emitted bit.
`timescale 1ns/1ps
module tb_mm_operand_serializer;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         a_bit;
   logic         b_bit;
   logic         bit_valid;
   logic         word_done;
   logic         busy;

   int tests = 0;
   int fails = 0;

   // expected bit stream {a, b, done} and expected words {a, b}
   logic [2:0]     bq[$];
   logic [2*W-1:0] wq[$];

   int run = 0;
   int max_run = 0;
   int done_cnt = 0;

   logic [W-1:0] ds_a = '0;
   logic [W-1:0] ds_b = '0;

   mm_operand_serializer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .a_bit    (a_bit),
      .b_bit    (b_bit),
      .bit_valid(bit_valid),
      .word_done(word_done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Monitor: downstream deserializer plus scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      logic [2:0]     e;
      logic [2*W-1:0] w;
      logic [2*W-1:0] p_ref;
      logic [2*W-1:0] p_ds;
      if (rst_n) begin
         ds_a = {ds_a[W-2:0], a_bit};
         ds_b = {ds_b[W-2:0], b_bit};
         if (bit_valid) begin
            run++;
            if (run > max_run) max_run = run;
            tests++;
            if (bq.size() == 0) begin
               fails++;
               $display("FAIL bit_extra: got bit_valid=1 a=%b b=%b, required no bit", a_bit, b_bit);
            end else begin
               e = bq.pop_front();
               if ({a_bit, b_bit, word_done} !== e) begin
                  fails++;
                  $display("FAIL bit_stream: got a/b/done=%b%b%b, required %b", a_bit, b_bit, word_done, e);
               end
            end
            if (word_done) begin
               done_cnt++;
               tests++;
               if (wq.size() == 0) begin
                  fails++;
                  $display("FAIL word_extra: got word_done with no expected word");
               end else begin
                  w = wq.pop_front();
                  if ({ds_a, ds_b} !== w) begin
                     fails++;
                     $display("FAIL deser_word: got a=%h b=%h, required a=%h b=%h", ds_a, ds_b, w[2*W-1:W], w[W-1:0]);
                  end
                  p_ref = {{W{1'b0}}, w[2*W-1:W]} * {{W{1'b0}}, w[W-1:0]};
                  p_ds  = {{W{1'b0}}, ds_a} * {{W{1'b0}}, ds_b};
                  tests++;
                  if ((^p_ds) !== (^p_ref)) begin
                     fails++;
                     $display("FAIL parity: got %b, required %b", ^p_ds, ^p_ref);
                  end
               end
            end
         end else begin
            run = 0;
            tests++;
            if ({a_bit, b_bit, word_done} !== 3'b000) begin
               fails++;
               $display("FAIL idle_out: got a/b/done=%b%b%b, required 000", a_bit, b_bit, word_done);
            end
         end
      end
   end

   // Present a pair and hold it until the handshake; records the expected stream.
   task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             output int waited, output logic at_done);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      #1;
      waited = 0;
      while (!in_ready && waited < 4 * W) begin
         @(negedge clk);
         #1;
         waited++;
      end
      at_done = word_done;
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, required 1", waited);
      end else begin
         wq.push_back({a, b});
         for (int i = W - 1; i >= 0; i--)
            bq.push_back({a[i], b[i], (i == 0) ? 1'b1 : 1'b0});
      end
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((busy || bq.size() != 0) && k < 8 * W) begin
         @(negedge clk);
         in_a = W'($urandom);
         in_b = W'($urandom);
         k++;
      end
      @(negedge clk);
      tests++;
      if (busy || bq.size() != 0) begin
         fails++;
         $display("FAIL drain: got busy=%b pending_bits=%0d, required busy=0 pending=0", busy, bq.size());
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      #1;
      tests++;
      if ({a_bit, b_bit, bit_valid, word_done, busy, in_ready} !== 6'b000001) begin
         fails++;
         $display("FAIL reset_state: got a/b/bv/wd/busy/rdy=%b%b%b%b%b%b, required 000001",
                  a_bit, b_bit, bit_valid, word_done, busy, in_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int   waited;
      logic at_done;
      int   d0;
      d0 = done_cnt;
      max_run = 0;
      drive_pair(16'hA5C3, 16'h0001, waited, at_done);
      idle_inputs();
      #1;
      tests++;
      if (bit_valid !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL single_hold: got bit_valid=%b busy=%b, required 0 1", bit_valid, busy);
      end
      @(negedge clk);
      #1;
      tests++;
      if (bit_valid !== 1'b1 || a_bit !== 1'b1 || b_bit !== 1'b0) begin
         fails++;
         $display("FAIL single_latency: got bv/a/b=%b%b%b, required 110", bit_valid, a_bit, b_bit);
      end
      wait_drain();
      tests++;
      if (max_run != 16 || done_cnt - d0 != 1) begin
         fails++;
         $display("FAIL single_len: got run=%0d words=%0d, required 16 1", max_run, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      int   waited;
      logic at_done;
      int   d0;
      d0 = done_cnt;
      max_run = 0;
      drive_pair(16'hFFFF, 16'h0000, waited, at_done);
      drive_pair(16'h8000, 16'h8000, waited, at_done);
      drive_pair(16'h1234, 16'h4321, waited, at_done);
      idle_inputs();
      wait_drain();
      tests++;
      if (max_run != 48 || done_cnt - d0 != 3) begin
         fails++;
         $display("FAIL b2b_run: got run=%0d words=%0d, required 48 3", max_run, done_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int   waited;
      logic at_done;
      drive_pair(16'h5A5A, 16'h3C3C, waited, at_done);
      drive_pair(16'hC001, 16'h7FFE, waited, at_done);
      drive_pair(16'h0F0F, 16'hF0F0, waited, at_done);
      tests++;
      if (waited == 0 || at_done !== 1'b1) begin
         fails++;
         $display("FAIL backpressure: got waited=%0d accept_at_done=%b, required >0 1", waited, at_done);
      end
      idle_inputs();
      wait_drain();
   endtask

   task automatic test_reset_midword();
      int   waited;
      logic at_done;
      drive_pair(16'hDEAD, 16'hBEEF, waited, at_done);
      drive_pair(16'h1357, 16'h2468, waited, at_done);
      idle_inputs();
      repeat (8) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({a_bit, b_bit, bit_valid, word_done, busy, in_ready} !== 6'b000001) begin
         fails++;
         $display("FAIL reset_mid: got a/b/bv/wd/busy/rdy=%b%b%b%b%b%b, required 000001",
                  a_bit, b_bit, bit_valid, word_done, busy, in_ready);
      end
      bq.delete();
      wq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive_pair(16'h0F0F, 16'h0F0F, waited, at_done);
      idle_inputs();
      wait_drain();
   endtask

   task automatic test_random_end_to_end();
      int   waited;
      logic at_done;
      int   d0;
      d0 = done_cnt;
      for (int n = 0; n < 30; n++) begin
         drive_pair(W'($urandom), W'($urandom), waited, at_done);
         if ($urandom_range(0, 2) == 0) begin
            for (int g = 0; g < int'($urandom_range(1, 20)); g++) idle_inputs();
         end
      end
      idle_inputs();
      wait_drain();
      tests++;
      if (done_cnt - d0 != 30) begin
         fails++;
         $display("FAIL random_words: got %0d words, required 30", done_cnt - d0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_midword();
      test_random_end_to_end();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
